// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs 24-bit RGB pixels densely into 32-bit AXI4-Stream
// words (four pixels -> three words), line by line, through a small FWFT FIFO.
// sof is carried to tuser on the first word of a frame, last_x to tlast.
module pixel_stream_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        sof_in,
  input  logic        last_x_in,
  output logic        ready_out,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        sof_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_FILL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {ACCEPT, FLUSH} state_t;

  state_t        state, state_next;
  logic [47:0]   acc, acc_next;
  logic [2:0]    cnt, cnt_next;
  logic          sof_pending, sof_pending_next;
  logic          sof_err_next;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fill;
  logic [33:0]   mem [FIFO_DEPTH];
  logic [33:0]   head;

  logic          fifo_full;
  logic          accept;
  logic          restart;
  logic          tuser_eff;
  logic [47:0]   base_acc, appended;
  logic [2:0]    base_cnt, new_cnt;
  logic          push, pop;
  logic [33:0]   push_word;

  // Reset is folded in so upstream sees ready low the moment reset_n drops.
  assign fifo_full = (fill == FULL_FILL);
  assign ready_out = reset_n && (state == ACCEPT) && !fifo_full;
  assign accept    = valid_in && ready_out;

  assign head     = mem[rd_ptr];
  assign m_tvalid = (fill != '0);
  assign m_tdata  = m_tvalid ? head[31:0] : 32'h0;
  assign m_tlast  = m_tvalid && head[32];
  assign m_tuser  = m_tvalid && head[33];
  assign pop      = m_tvalid && m_tready;

  // Append the incoming pixel to the byte accumulator and decide what word, if any, is written this edge.
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    cnt_next         = cnt;
    sof_pending_next = sof_pending;
    sof_err_next     = sof_err;
    push             = 1'b0;
    push_word        = '0;

    restart   = sof_in && (cnt != 3'd0);
    base_acc  = restart ? 48'h0 : acc;
    base_cnt  = restart ? 3'd0 : cnt;
    appended  = base_acc | ({24'h0, b_in, g_in, r_in} << {base_cnt, 3'b000});
    new_cnt   = base_cnt + 3'd3;
    tuser_eff = sof_pending || (accept && sof_in);

    case (state)
      ACCEPT: begin
        if (accept) begin
          if (restart) sof_err_next = 1'b1;
          if (last_x_in) begin
            push = 1'b1;
            if (new_cnt == 3'd3) begin
              push_word = {tuser_eff, 1'b1, 8'h00, appended[23:0]};
              acc_next  = 48'h0;
              cnt_next  = 3'd0;
            end else if (new_cnt == 3'd4) begin
              push_word = {tuser_eff, 1'b1, appended[31:0]};
              acc_next  = 48'h0;
              cnt_next  = 3'd0;
            end else begin
              push_word  = {tuser_eff, 1'b0, appended[31:0]};
              acc_next   = {32'h0, appended[47:32]};
              cnt_next   = new_cnt - 3'd4;
              state_next = FLUSH;
            end
          end else if (new_cnt >= 3'd4) begin
            push      = 1'b1;
            push_word = {tuser_eff, 1'b0, appended[31:0]};
            acc_next  = {32'h0, appended[47:32]};
            cnt_next  = new_cnt - 3'd4;
          end else begin
            acc_next = appended;
            cnt_next = new_cnt;
          end
          sof_pending_next = push ? 1'b0 : tuser_eff;
        end
      end
      FLUSH: begin
        if (!fifo_full) begin
          push             = 1'b1;
          push_word        = {sof_pending, 1'b1, acc[31:0]};
          acc_next         = 48'h0;
          cnt_next         = 3'd0;
          sof_pending_next = 1'b0;
          state_next       = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  // Packer state register: FSM state, accumulator and frame flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCEPT;
      acc         <= 48'h0;
      cnt         <= 3'd0;
      sof_pending <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      sof_pending <= sof_pending_next;
      sof_err     <= sof_err_next;
    end
  end

  // FIFO storage; contents need no reset because fill gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and fill count; a push is never issued while full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (PW+1)'(1);
        2'b01:   fill <= fill - (PW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench for pixel_stream_packer: a byte-queue reference model
// produces expected words, a monitor collects handshaken output words.
module tb_pixel_stream_packer;

  localparam int FIFO_DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [7:0]  r_in, g_in, b_in;
  logic        sof_in, last_x_in;
  logic        ready_out;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        sof_err;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [7:0]  byte_q[$];
  logic        model_sof_pend;
  logic        rand_done;
  int          vectors;
  int          miscompares;

  pixel_stream_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .sof_in    (sof_in),
    .last_x_in (last_x_in),
    .ready_out (ready_out),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every word that completes a handshake at the coming rising edge.
  always @(negedge clk) begin
    if (reset_n && m_tvalid && m_tready)
      obs_q.push_back({m_tuser, m_tlast, m_tdata});
  end

  // Reference model: emit one expected word from the front of the byte queue.
  task automatic model_emit(input logic tl);
    logic [31:0] w;
    int n;
    w = 32'h0;
    n = (byte_q.size() < 4) ? byte_q.size() : 4;
    for (int i = 0; i < n; i++) w[8*i +: 8] = byte_q.pop_front();
    exp_q.push_back({model_sof_pend, tl, w});
    model_sof_pend = 1'b0;
  endtask

  // Reference model: account for one accepted pixel.
  task automatic model_accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic sof, input logic last);
    if (sof && byte_q.size() != 0) byte_q.delete();
    if (sof) model_sof_pend = 1'b1;
    byte_q.push_back(r);
    byte_q.push_back(g);
    byte_q.push_back(b);
    while (byte_q.size() > 4 || (byte_q.size() == 4 && !last)) model_emit(1'b0);
    if (last) model_emit(1'b1);
  endtask

  // Present one pixel and hold it until accepted; returns cycles spent waiting.
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic sof, input logic last, output int waited);
    valid_in  = 1'b1;
    r_in      = r;
    g_in      = g;
    b_in      = b;
    sof_in    = sof;
    last_x_in = last;
    waited    = 0;
    @(negedge clk);
    while (!ready_out && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!ready_out) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: ready_out stayed %b, required 1", ready_out);
      valid_in = 1'b0;
    end else begin
      model_accept(r, g, b, sof, last);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    sof_in    = 1'b0;
    last_x_in = 1'b0;
  endtask

  // Bounded wait for the monitor to catch up with the model.
  task automatic wait_outputs();
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    m_tready = 1'b1;
    idle();
    r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
    #1;
    vectors++;
    if ({ready_out, m_tvalid, m_tlast, m_tuser, sof_err} !== 5'b0 || m_tdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b last=%b user=%b err=%b data=%h, required all 0",
               ready_out, m_tvalid, m_tlast, m_tuser, sof_err, m_tdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b1 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got rdy=%b vld=%b, required rdy=1 vld=0", ready_out, m_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_line();
    int w, tot;
    logic [33:0] e, o;
    tot = 0;
    send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0, w); tot += w;
    send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0, w); tot += w;
    send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0, w); tot += w;
    send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1, w); tot += w;
    idle();
    @(negedge clk);
    vectors++;
    if (tot != 0 || ready_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_ready: stall cycles %0d rdy=%b, required 0 and 1", tot, ready_out);
    end
    vectors++;
    if (exp_q.size() != 3 || exp_q[0] !== 34'h2_0403_0201) begin
      miscompares++;
      $display("[TB] FAIL basic_model: model gave %0d words, first %h, required 3 and 204030201",
               exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 34'h0);
    end
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL basic_word: got %h expected %h", o, e);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_single_pixel();
    int w;
    logic [33:0] e, o;
    send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1, w);
    idle();
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e || o !== 34'h1_00CC_BBAA) begin
        miscompares++;
        $display("[TB] FAIL single_word: got %h expected %h", o, 34'h1_00CC_BBAA);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_flush_bubble();
    int w;
    logic [33:0] e, o;
    send_pixel(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, w);
    send_pixel(8'h44, 8'h55, 8'h66, 1'b0, 1'b1, w);
    idle();
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_ready_low: got %b required 0", ready_out);
    end
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_ready_back: got %b required 1", ready_out);
    end
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL flush_word: got %h expected %h", o, e);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_stall();
    int w, tot;
    logic [33:0] e, o;
    m_tready = 1'b0;
    tot = 0;
    for (int i = 0; i < 22; i++) begin
      send_pixel(8'(3*i), 8'(3*i+1), 8'(3*i+2), 1'b0, 1'b0, w);
      tot += w;
    end
    idle();
    @(negedge clk);
    vectors++;
    if (tot != 0 || ready_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_full: stall cycles %0d rdy=%b, required 0 and 0", tot, ready_out);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_q[0][31:0]) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got vld=%b data=%h required 1 and %h", m_tvalid, m_tdata, exp_q[0][31:0]);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    fork
      send_pixel(8'hF0, 8'hF1, 8'hF2, 1'b0, 1'b1, w);
      begin
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    idle();
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL stall_word: got %h expected %h", o, e);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int w, len;
    logic [33:0] e, o;
    rand_done = 1'b0;
    fork
      begin
        for (int l = 0; l < 6; l++) begin
          len = $urandom_range(1, 9);
          for (int i = 0; i < len; i++)
            send_pixel(8'($urandom), 8'($urandom), 8'($urandom), (i == 0), (i == len - 1), w);
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
      end
    join
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL b2b_word: got %h expected %h", o, e);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_sof_error();
    int w;
    logic [33:0] e, o;
    @(negedge clk);
    vectors++;
    if (sof_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sof_err_clean: got %b required 0", sof_err);
    end
    @(posedge clk);
    #1;
    send_pixel(8'h99, 8'h98, 8'h97, 1'b0, 1'b0, w);
    send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b1, w);
    idle();
    @(negedge clk);
    vectors++;
    if (sof_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sof_err_set: got %b required 1", sof_err);
    end
    wait_outputs();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e || o !== 34'h3_0003_0201) begin
        miscompares++;
        $display("[TB] FAIL sof_word: got %h expected %h", o, 34'h3_0003_0201);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sof_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_reset_midline();
    int w;
    logic [33:0] e, o;
    m_tready = 1'b0;
    send_pixel(8'h31, 8'h32, 8'h33, 1'b0, 1'b0, w);
    send_pixel(8'h34, 8'h35, 8'h36, 1'b0, 1'b0, w);
    idle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({ready_out, m_tvalid, m_tlast, m_tuser, sof_err} !== 5'b0 || m_tdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midline_reset: got rdy=%b vld=%b last=%b user=%b err=%b data=%h, required all 0",
               ready_out, m_tvalid, m_tlast, m_tuser, sof_err, m_tdata);
    end
    exp_q.delete();
    obs_q.delete();
    byte_q.delete();
    model_sof_pend = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b1 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midline_release: got rdy=%b vld=%b, required 1 and 0", ready_out, m_tvalid);
    end
    @(posedge clk);
    #1;
    send_pixel(8'hD1, 8'hD2, 8'hD3, 1'b0, 1'b0, w);
    send_pixel(8'hE1, 8'hE2, 8'hE3, 1'b0, 1'b1, w);
    idle();
    wait_outputs();
    vectors++;
    if (obs_q.size() == 0 || obs_q[0] !== 34'h0_E1D3_D2D1) begin
      miscompares++;
      $display("[TB] FAIL midline_lane0: got %h required 0e1d3d2d1",
               (obs_q.size() != 0) ? obs_q[0] : 34'h0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL midline_word: got %h expected %h", o, e);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midline_count: %0d expected and %0d observed words left over", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors        = 0;
    miscompares    = 0;
    model_sof_pend = 1'b0;
    rand_done      = 1'b0;
    test_reset();
    test_basic_line();
    test_single_pixel();
    test_flush_bubble();
    test_stall();
    test_back_to_back();
    test_sof_error();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sits directly downstream of the ray tracing unit.
- Consumes its 8-bit R/G/B pixel stream together with the valid, sof and last_x flags, and drives the ready_external backpressure back to it.
- Packs 24-bit pixels densely into 32-bit AXI4-Stream words, so four pixels become three words, for the VDMA/video DMA path.
- Buffers packed words in a small first-word-fall-through FIFO and maps sof to tuser and last_x to tlast.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit output words buffered; power of two, minimum 4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  upstream pixel valid
- r_in  in  8  red
- g_in  in  8  green
- b_in  in  8  blue
- sof_in  in  1  pixel is the first pixel of a frame
- last_x_in  in  1  pixel is the last pixel of a line
- ready_out  out  1  to upstream ready_external; pixel accepted when valid_in & ready_out
- m_tdata  out  32  packed output word
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last word of a line
- m_tuser  out  1  first word of a frame
- sof_err  out  1  sticky: sof arrived with a partial line pending

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
- While reset_n=0, all of the following are forced low or cleared:
  - outputs: ready_out, m_tvalid, m_tdata, m_tlast, m_tuser, sof_err
  - state: accumulator, byte count, FIFO pointers and fill count, sof_pending; state=ACCEPT.
- Reset asserted mid-line discards all buffered data. No partial word is emitted afterwards.
- Byte order: each pixel contributes bytes R, G, B in that order to increasing byte lanes, lane0 = bits[7:0].
- Packing is continuous across pixels within a line and never crosses a line boundary.
- Accumulator: 48-bit byte register plus a 3-bit count (0..6). Count is always 0..3 between accepts.
- On accept, the 3 new bytes are appended above the existing count.
  - If the new count is ≥4, the low 4 bytes form a word that is written to the FIFO in the same edge. The remainder shifts down and the count drops by 4.
- last_x accept, by count after append (c):
  - c=3: one word {8'h00, bytes[2:0]}, tlast=1.
  - c=4: one full word, tlast=1.
  - c=5 or 6: full word with tlast=0 this edge, then enter FLUSH. FLUSH writes the remainder zero-padded in the upper lanes with tlast=1.
  - After any last_x handling the count is 0.
- tuser:
  - Accepting sof_in sets sof_pending.
  - The first word written to the FIFO at or after that accept carries tuser=1 and clears sof_pending.
- sof_in accepted while count≠0 (the upstream dropped last_x):
  - Discard the old bytes. The count restarts at 0 before appending.
  - Set sof_err; it is cleared only by reset.
- FSM states:
  - ACCEPT: ready_out = (FIFO free entries ≥1). Moves to FLUSH only as described above.
  - FLUSH: ready_out=0. The final word is written when free ≥1, then return to ACCEPT. FLUSH waits indefinitely while the FIFO is full.
- ready_out is combinational from registered state and fill only. It does not depend on valid_in.
- FIFO:
  - Width 34 bits: {tuser, tlast, tdata}. First-word-fall-through.
  - m_tvalid = fill≠0. Pop on m_tvalid & m_tready.
  - A simultaneous push and pop with fill=FIFO_DEPTH is illegal, because ready_out already blocks the push.
  - Simultaneous push and pop at any other fill leaves fill unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a word written at accept edge N shows m_tvalid=1 after edge N when the FIFO was empty, i.e. 1 cycle.
- While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tuser hold stable.
- Throughput: with m_tready held at 1, one pixel is accepted per cycle, except for one bubble per line whose final count is 5 or 6.

Test Plan:
- 4-pixel line (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C), first pixel sof, m_tready=1 -> words 0x04030201 tuser=1, 0x08070605, 0x0C0B0A09 tlast=1; ready_out stays 1 throughout.
- 1-pixel line (AA,BB,CC) with last_x -> single word 0x00CCBBAA, tlast=1.
- 2-pixel line (11,22,33),(44,55,66) -> 0x44332211 tlast=0, then 0x00006655 tlast=1; ready_out=0 for exactly one cycle (FLUSH).
- Hold m_tready=0 with continuous valid_in -> ready_out drops after FIFO_DEPTH words are buffered; release m_tready -> words emerge in order, no loss or duplication; m_tdata stable while stalled.
- Send 1 pixel without last_x, then a sof pixel (01,02,03) with last_x -> sof_err=1; output 0x00030201 tuser=1 tlast=1; the stale bytes never appear.
- Assert reset_n=0 mid-line with FIFO non-empty -> m_tvalid=0 and ready_out=0 immediately (asynchronous), before the next clock edge; after release, ready_out=1 and the next line packs from byte lane 0.
